// File: rtl/spi_mem_pkg.sv
// Shared definitions for the SPI burst memory: FSM state encoding and command R/W codes.
package spi_mem_pkg;
  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 3'd0,
    CMD       = 3'd1,
    RD_LOAD   = 3'd2,
    RD_DATA   = 3'd3,
    WR_DATA   = 3'd4,
    WR_COMMIT = 3'd5
  } state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;
endpackage

// File: rtl/spi_burst_memory_if.sv
// Board-side SPI pin bundle; the memory is the slave, the board/bench the master.
interface spi_burst_memory_if;
  logic sclk_pin;
  logic cs_pin;
  logic mosi_pin;
  logic miso_pin;
  logic miso_oe;

  modport slave  (input sclk_pin, cs_pin, mosi_pin, output miso_pin, miso_oe);
  modport master (output sclk_pin, cs_pin, mosi_pin, input miso_pin, miso_oe);
endinterface

// File: rtl/spi_pin_sync.sv
// Multi-flop synchroniser for one asynchronous pin, with registered one-clk edge pulses.
module spi_pin_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;
  logic                   rise_reg;
  logic                   fall_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg <= {SYNC_STAGES{RST_VAL}};
      prev_reg <= RST_VAL;
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], pin};
      prev_reg <= sync_reg[SYNC_STAGES-1];
      rise_reg <= sync_reg[SYNC_STAGES-1] & ~prev_reg;
      fall_reg <= ~sync_reg[SYNC_STAGES-1] & prev_reg;
    end
  end

  assign level = sync_reg[SYNC_STAGES-1];
  assign rise  = rise_reg;
  assign fall  = fall_reg;
endmodule

// File: rtl/spi_burst_memory.sv
// SPI slave with burst read/write into on-chip RAM, address auto-increment and write protect.
module spi_burst_memory
  import spi_mem_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 2**ADDR_W,
  parameter int SYNC_STAGES = 2,
  parameter int LSB_FIRST   = 0
) (
  input  logic                clk,
  input  logic                reset,
  spi_burst_memory_if.slave   spi,
  input  logic                write_protect,
  output logic [STATE_W-1:0]  state_dbg,
  output logic [7:0]          frame_count
);
  localparam int RX_W  = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;
  localparam int IDX_W = $clog2(RX_W);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [2:0] PIN_RST = 3'b010;  // cs idles high, sclk/mosi low

  logic [2:0] pin_in, pin_lvl, pin_rise, pin_fall;
  assign pin_in = {spi.mosi_pin, spi.cs_pin, spi.sclk_pin};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(PIN_RST[gi])) u_sync (
        .clk(clk), .reset(reset), .pin(pin_in[gi]),
        .level(pin_lvl[gi]), .rise(pin_rise[gi]), .fall(pin_fall[gi])
      );
    end
  endgenerate

  logic sclk_rise, sclk_fall, cs_high, mosi_lvl;
  assign sclk_rise = pin_rise[0];
  assign sclk_fall = pin_fall[0];
  assign cs_high   = pin_lvl[1];
  assign mosi_lvl  = pin_lvl[2];

  logic unused_pins;
  assign unused_pins = ^{pin_lvl[0], pin_rise[2:1], pin_fall[2:1]};

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    bit_cnt_reg, bit_cnt_next;
  logic [RX_W-1:0]     rx_reg, rx_next, rx_in;
  logic [DATA_W-1:0]   tx_reg, tx_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [7:0]          fc_reg, fc_next;
  logic                oe_reg, oe_next;
  logic                armed_reg, armed_next;
  logic                load_phase_reg, load_phase_next;
  logic [DATA_W-1:0]   rd_data_reg;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                mem_we;
  logic [IDX_W-1:0]    bit_idx;

  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return (32'(a) == DEPTH - 1) ? '0 : a + 1'b1;
  endfunction

  assign bit_idx = bit_cnt_reg[IDX_W-1:0];

  always_comb begin
    rx_in = rx_reg;
    if (LSB_FIRST != 0) rx_in[bit_idx] = mosi_lvl;
    else                rx_in = {rx_reg[RX_W-2:0], mosi_lvl};
  end

  always_comb begin
    state_next      = state_reg;
    bit_cnt_next    = bit_cnt_reg;
    rx_next         = rx_reg;
    tx_next         = tx_reg;
    addr_next       = addr_reg;
    fc_next         = fc_reg;
    oe_next         = oe_reg;
    armed_next      = armed_reg;
    load_phase_next = load_phase_reg;
    case (state_reg)
      IDLE: begin
        oe_next = 1'b0;
        if (!cs_high) begin
          state_next   = CMD;
          bit_cnt_next = '0;
          armed_next   = 1'b0;
        end
      end
      CMD: if (sclk_rise) begin
        rx_next = rx_in;
        if (bit_cnt_reg == CNT_W'(ADDR_W)) begin
          addr_next       = ADDR_W'(32'(rx_in[ADDR_W:1]) % DEPTH);
          bit_cnt_next    = '0;
          load_phase_next = 1'b0;
          state_next      = (rx_in[0] == RW_READ) ? RD_LOAD : WR_DATA;
        end else begin
          bit_cnt_next = bit_cnt_reg + 1'b1;
        end
      end
      RD_LOAD: begin
        // phase 0 lets the registered RAM read settle, phase 1 loads the shifter
        if (!load_phase_reg) begin
          load_phase_next = 1'b1;
        end else begin
          tx_next         = rd_data_reg;
          oe_next         = 1'b1;
          armed_next      = 1'b0;
          load_phase_next = 1'b0;
          state_next      = RD_DATA;
        end
      end
      RD_DATA: begin
        if (sclk_rise) begin
          armed_next = 1'b1;
          if (bit_cnt_reg == CNT_W'(DATA_W - 1)) begin
            bit_cnt_next = '0;
            fc_next      = fc_reg + 1'b1;
            addr_next    = addr_inc(addr_reg);
            state_next   = RD_LOAD;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end else if (sclk_fall && armed_reg) begin
          if (LSB_FIRST != 0) tx_next = {1'b0, tx_reg[DATA_W-1:1]};
          else                tx_next = {tx_reg[DATA_W-2:0], 1'b0};
        end
      end
      WR_DATA: if (sclk_rise) begin
        rx_next = rx_in;
        if (bit_cnt_reg == CNT_W'(DATA_W - 1)) begin
          bit_cnt_next = '0;
          state_next   = WR_COMMIT;
        end else begin
          bit_cnt_next = bit_cnt_reg + 1'b1;
        end
      end
      WR_COMMIT: begin
        fc_next    = fc_reg + 1'b1;
        addr_next  = addr_inc(addr_reg);
        state_next = WR_DATA;
      end
      default: state_next = IDLE;
    endcase
    // Deselect overrides any same-cycle SCLK edge or commit
    if (state_reg != IDLE && cs_high) begin
      state_next   = IDLE;
      oe_next      = 1'b0;
      bit_cnt_next = '0;
      fc_next      = fc_reg;
      addr_next    = addr_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      bit_cnt_reg    <= '0;
      rx_reg         <= '0;
      tx_reg         <= '0;
      addr_reg       <= '0;
      fc_reg         <= '0;
      oe_reg         <= 1'b0;
      armed_reg      <= 1'b0;
      load_phase_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      rx_reg         <= rx_next;
      tx_reg         <= tx_next;
      addr_reg       <= addr_next;
      fc_reg         <= fc_next;
      oe_reg         <= oe_next;
      armed_reg      <= armed_next;
      load_phase_reg <= load_phase_next;
    end
  end

  assign mem_we = (state_reg == WR_COMMIT) && !write_protect && !cs_high && !reset;

  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_reg] <= rx_reg[DATA_W-1:0];
    rd_data_reg <= mem[addr_reg];
  end

  assign spi.miso_pin = oe_reg ? ((LSB_FIRST != 0) ? tx_reg[0] : tx_reg[DATA_W-1]) : 1'bz;
  assign spi.miso_oe  = oe_reg;
  assign state_dbg    = state_reg;
  assign frame_count  = fc_reg;
endmodule

// File: tb/tb_spi_burst_memory.sv
// Directed bench: default-parameter memory plus an LSB-first 4-bit-address/16-bit-data instance.
module tb_spi_burst_memory;
  localparam int HALF = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sclk = 1'b0;
  logic mosi = 1'b0;
  logic cs_a = 1'b1;
  logic cs_b = 1'b1;
  logic wp = 1'b0;
  logic [2:0] state_a, state_b;
  logic [7:0] fc_a, fc_b;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  spi_burst_memory_if spi_a ();
  spi_burst_memory_if spi_b ();
  assign spi_a.sclk_pin = sclk;
  assign spi_a.mosi_pin = mosi;
  assign spi_a.cs_pin   = cs_a;
  assign spi_b.sclk_pin = sclk;
  assign spi_b.mosi_pin = mosi;
  assign spi_b.cs_pin   = cs_b;

  spi_burst_memory dut_a (
    .clk(clk), .reset(reset), .spi(spi_a), .write_protect(wp),
    .state_dbg(state_a), .frame_count(fc_a)
  );

  spi_burst_memory #(.ADDR_W(4), .DATA_W(16), .LSB_FIRST(1)) dut_b (
    .clk(clk), .reset(reset), .spi(spi_b), .write_protect(1'b0),
    .state_dbg(state_b), .frame_count(fc_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_cs(input bit sel_b, input logic v);
    if (sel_b) cs_b = v;
    else       cs_a = v;
  endtask

  // Mode-0 master: MOSI changes with SCLK low, MISO sampled on the rising edge
  task automatic xfer(input bit sel_b, input int n, input logic [31:0] dout,
                      input bit lsb, output logic [31:0] din);
    din = '0;
    for (int i = 0; i < n; i++) begin
      int bi = lsb ? i : n - 1 - i;
      mosi = dout[bi];
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      din[bi] = sel_b ? spi_b.miso_pin : spi_a.miso_pin;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_txn(input bit sel_b, input int aw, input int dw, input bit lsb,
                         input logic [31:0] cmd, input int nwords,
                         input logic [31:0] d0, input logic [31:0] d1,
                         output logic [31:0] r0, output logic [31:0] r1);
    logic [31:0] junk;
    r0 = '0;
    r1 = '0;
    set_cs(sel_b, 1'b0);
    repeat (HALF) @(negedge clk);
    xfer(sel_b, aw + 1, cmd, lsb, junk);
    if (nwords > 0) xfer(sel_b, dw, d0, lsb, r0);
    if (nwords > 1) xfer(sel_b, dw, d1, lsb, r1);
    repeat (4) @(negedge clk);
    set_cs(sel_b, 1'b1);
    repeat (2 * HALF) @(negedge clk);
    $display("xact dut=%0d cmd=0x%0h words=%0d d0=0x%0h d1=0x%0h r0=0x%0h r1=0x%0h",
             sel_b, cmd, nwords, d0, d1, r0, r1);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r0, r1, junk;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_state", 32'(state_a), 32'd0);
    check("rst_fc", 32'(fc_a), 32'd0);
    check("rst_oe", 32'(spi_a.miso_oe), 32'd0);

    // 1: single write then single read
    spi_txn(0, 7, 8, 0, 32'h24, 1, 32'h5A, 0, r0, r1);
    spi_txn(0, 7, 8, 0, 32'h25, 1, 0, 0, r0, r1);
    check("t1_read", r0, 32'h5A);
    check("t1_fc", 32'(fc_a), 32'd2);
    check("t1_oe_idle", 32'(spi_a.miso_oe), 32'd0);

    // 2: burst across the top address
    spi_txn(0, 7, 8, 0, 32'hFE, 2, 32'h11, 32'h22, r0, r1);
    spi_txn(0, 7, 8, 0, 32'hFF, 2, 0, 0, r0, r1);
    check("t2_rd0", r0, 32'h11);
    check("t2_rd1_wrap", r1, 32'h22);
    check("t2_fc", 32'(fc_a), 32'd6);

    // 3: write protect
    spi_txn(0, 7, 8, 0, 32'h06, 1, 32'h3C, 0, r0, r1);
    wp = 1'b1;
    spi_txn(0, 7, 8, 0, 32'h06, 1, 32'hFF, 0, r0, r1);
    wp = 1'b0;
    check("t3_fc_prot", 32'(fc_a), 32'd8);
    spi_txn(0, 7, 8, 0, 32'h07, 1, 0, 0, r0, r1);
    check("t3_read", r0, 32'h3C);

    // 4: aborted write frame
    spi_txn(0, 7, 8, 0, 32'h20, 1, 32'hA5, 0, r0, r1);
    cs_a = 1'b0;
    repeat (HALF) @(negedge clk);
    xfer(0, 8, 32'h20, 0, junk);
    xfer(0, 5, 32'h1F, 0, junk);
    cs_a = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    $display("xact dut=0 cmd=0x20 partial 5 bits");
    check("t4_state", 32'(state_a), 32'd0);
    check("t4_oe", 32'(spi_a.miso_oe), 32'd0);
    check("t4_fc", 32'(fc_a), 32'd10);
    spi_txn(0, 7, 8, 0, 32'h21, 1, 0, 0, r0, r1);
    check("t4_read", r0, 32'hA5);

    // 5: reset in the middle of a read frame
    cs_a = 1'b0;
    repeat (HALF) @(negedge clk);
    xfer(0, 8, 32'h25, 0, junk);
    xfer(0, 3, 32'h0, 0, junk);
    check("t5_oe_before", 32'(spi_a.miso_oe), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("t5_oe_after", 32'(spi_a.miso_oe), 32'd0);
    check("t5_fc", 32'(fc_a), 32'd0);
    check("t5_state", 32'(state_a), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cs_a = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    $display("xact dut=0 reset during read");
    spi_txn(0, 7, 8, 0, 32'h25, 1, 0, 0, r0, r1);
    check("t5_read", r0, 32'h5A);
    check("t5_fc_after", 32'(fc_a), 32'd1);

    // 6: LSB-first wide instance
    spi_txn(1, 4, 16, 1, 32'h12, 1, 32'hBEEF, 0, r0, r1);
    spi_txn(1, 4, 16, 1, 32'h13, 1, 0, 0, r0, r1);
    check("t6_read", r0, 32'hBEEF);
    check("t6_fc", 32'(fc_b), 32'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
